compute_t: RTL



---
 rtl/compute_t.sv | 120 ++++++++++++
 1 files changed

// File: rtl/compute_t.sv
// T = S'*C for one 8x8 block: reads DPRAM0[64..127], writes DPRAM1[0..63]; 17 cycles per row, 138 start-to-idle.
// No backpressure: fixed 1-cycle read latency assumed, CT_start is sampled only while idle.
module compute_t (
   input  logic        CLOCK_50_I,
   input  logic        Reset,
   input  logic        CT_start,
   output logic        CT_done,
   output logic [6:0]  CT_read_address,
   input  logic [31:0] CT_read_data,
   output logic [6:0]  CT_write_address,
   output logic [31:0] CT_write_data,
   output logic        CT_write_enable
);
   typedef enum logic [2:0] {S_CT_IDLE, S_CT_READ, S_CT_ACC, S_CT_WRITE, S_CT_DONE} state_t;

   // K_TAB[8*u + x]
   localparam logic signed [12:0] K_TAB [64] = '{
      13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,
      13'sd2008,  13'sd1702,  13'sd1137,  13'sd399,  -13'sd399,  -13'sd1137, -13'sd1702, -13'sd2008,
      13'sd1892,  13'sd783,  -13'sd783,  -13'sd1892, -13'sd1892, -13'sd783,   13'sd783,   13'sd1892,
      13'sd1702, -13'sd399,  -13'sd2008, -13'sd1137,  13'sd1137,  13'sd2008,  13'sd399,  -13'sd1702,
      13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,
      13'sd1137, -13'sd2008,  13'sd399,   13'sd1702, -13'sd1702, -13'sd399,   13'sd2008, -13'sd1137,
      13'sd783,  -13'sd1892,  13'sd1892, -13'sd783,  -13'sd783,   13'sd1892, -13'sd1892,  13'sd783,
      13'sd399,  -13'sd1137,  13'sd1702, -13'sd2008,  13'sd2008, -13'sd1702,  13'sd1137, -13'sd399
   };

   state_t             state_q, state_d;
   logic [2:0]         r_q, r_d, k_q, k_d, c_q, c_d;
   logic signed [31:0] acc_q [8];
   logic signed [31:0] acc_d [8];
   logic [6:0]         wr_addr_q, wr_addr_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic signed [31:0] s_ext;
   logic signed [31:0] wr_live;
   logic [2:0]         kk;
   logic               unused_hi;

   assign s_ext     = {{16{CT_read_data[15]}}, CT_read_data[15:0]};
   assign unused_hi = ^CT_read_data[31:16];
   assign wr_live   = acc_q[c_q] >>> 8;

   always_ff @(posedge CLOCK_50_I or posedge Reset) begin
      if (Reset) begin
         state_q   <= S_CT_IDLE;
         r_q       <= 3'd0;
         k_q       <= 3'd0;
         c_q       <= 3'd0;
         wr_addr_q <= 7'd0;
         wr_data_q <= 32'd0;
         for (int i = 0; i < 8; i++) acc_q[i] <= 32'sd0;
      end else begin
         state_q   <= state_d;
         r_q       <= r_d;
         k_q       <= k_d;
         c_q       <= c_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         for (int i = 0; i < 8; i++) acc_q[i] <= acc_d[i];
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_CT_IDLE:  if (CT_start) state_d = S_CT_READ;
         S_CT_READ:  if (k_q == 3'd7) state_d = S_CT_ACC;
         S_CT_ACC:   state_d = S_CT_WRITE;
         S_CT_WRITE: if (c_q == 3'd7) state_d = (r_q == 3'd7) ? S_CT_DONE : S_CT_READ;
         S_CT_DONE:  state_d = S_CT_IDLE;
         default:    state_d = S_CT_IDLE;
      endcase
   end

   // Read data lags the address by one cycle, so READ at k folds in column k-1 and ACC folds in k=7.
   always_comb begin
      r_d       = r_q;
      k_d       = k_q;
      c_d       = c_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      for (int i = 0; i < 8; i++) acc_d[i] = acc_q[i];
      kk = (state_q == S_CT_ACC) ? 3'd7 : k_q - 3'd1;
      case (state_q)
         S_CT_READ: begin
            k_d = k_q + 3'd1;
            for (int i = 0; i < 8; i++)
               acc_d[i] = (k_q == 3'd0) ? 32'sd0
                        : acc_q[i] + s_ext * 32'(K_TAB[{i[2:0], kk}]);
         end
         S_CT_ACC: begin
            c_d = 3'd0;
            for (int i = 0; i < 8; i++)
               acc_d[i] = acc_q[i] + s_ext * 32'(K_TAB[{i[2:0], kk}]);
         end
         S_CT_WRITE: begin
            c_d       = c_q + 3'd1;
            wr_addr_d = {1'b0, r_q, c_q};
            wr_data_d = wr_live;
            if (c_q == 3'd7 && r_q != 3'd7) begin
               r_d = r_q + 3'd1;
               k_d = 3'd0;
            end
         end
         default: begin
            r_d = 3'd0;
            k_d = 3'd0;
            c_d = 3'd0;
         end
      endcase
   end

   always_comb begin
      CT_done          = (state_q == S_CT_DONE);
      CT_write_enable  = (state_q == S_CT_WRITE);
      CT_read_address  = (state_q == S_CT_READ) ? {1'b1, r_q, k_q} : 7'd0;
      CT_write_address = CT_write_enable ? {1'b0, r_q, c_q} : wr_addr_q;
      CT_write_data    = CT_write_enable ? wr_live : wr_data_q;
   end
endmodule
